calc_mem_arbiter: RTL

- Shares the single-port calculator SRAM between NUM_REQ requesters, e.g. the calculator controller and a host loader/dumper.
- Round-robin arbitration with a lock mechanism. A requester can hold the memory for a read-then-write sequence.
- Sits between the requesters and the SRAM: drives read/write/addr/wdata to memory and routes the 1-cycle-latency read data back to the originating requester.

---
 rtl/calc_mem_arbiter.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/calc_mem_arbiter.sv
// Shares one single-port SRAM between NUM_REQ requesters: round-robin arbitration with
// per-requester lock, forced release after MAX_LOCK_CYCLES, read-data routing. Option: ARB_FIXED_PRIO_EN.
package calculator_pkg;
    localparam int ADDR_W        = 16;
    localparam int MEM_WORD_SIZE = 64;
endpackage

module calc_mem_arbiter #(
    parameter int NUM_REQ         = 2,
    parameter int MAX_LOCK_CYCLES = 16,
    parameter int ADDR_W          = calculator_pkg::ADDR_W,
    parameter int MEM_WORD_SIZE   = calculator_pkg::MEM_WORD_SIZE
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic [NUM_REQ-1:0]               req_i,
    input  logic [NUM_REQ-1:0]               we_i,
    input  logic [NUM_REQ-1:0]               lock_i,
    input  logic [NUM_REQ*ADDR_W-1:0]        addr_i,
    input  logic [NUM_REQ*MEM_WORD_SIZE-1:0] wdata_i,
    output logic [NUM_REQ-1:0]               gnt_o,
    output logic [NUM_REQ-1:0]               rvalid_o,
    output logic [MEM_WORD_SIZE-1:0]         rdata_o,
    output logic                             lock_err_o,
    output logic                             mem_read,
    output logic                             mem_write,
    output logic [ADDR_W-1:0]                mem_addr,
    output logic [MEM_WORD_SIZE-1:0]         mem_wdata,
    input  logic [MEM_WORD_SIZE-1:0]         mem_rdata
);
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_LOCK_CYCLES + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_LOCK_CYCLES - 1);

    typedef enum logic {S_ARB, S_LOCKED} state_t;

    state_t             state_reg, state_next;
    logic [IDX_W-1:0]   last_ptr_reg, last_ptr_next;
    logic [IDX_W-1:0]   owner_reg, owner_next;
    logic [IDX_W-1:0]   pick_idx;
    logic [CNT_W-1:0]   lock_cnt_reg, lock_cnt_next;
    logic [NUM_REQ-1:0] rvalid_reg, gnt;
    logic               lock_err_reg, lock_err_next;
    logic               pick_found, owner_holds;

    logic [ADDR_W-1:0]        addr_arr  [NUM_REQ];
    logic [MEM_WORD_SIZE-1:0] wdata_arr [NUM_REQ];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign addr_arr[gi]  = addr_i[gi*ADDR_W +: ADDR_W];
            assign wdata_arr[gi] = wdata_i[gi*MEM_WORD_SIZE +: MEM_WORD_SIZE];
        end
    endgenerate

    // Candidate for an open arbitration; loops run from worst to best so the last hit wins.
`ifdef ARB_FIXED_PRIO_EN
    always_comb begin
        pick_found = |req_i;
        pick_idx   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_i[k]) pick_idx = IDX_W'(k);
        end
    end
`else
    always_comb begin
        logic [IDX_W-1:0] cand;
        pick_found = |req_i;
        pick_idx   = '0;
        cand       = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand = IDX_W'((int'(last_ptr_reg) + k) % NUM_REQ);
            if (req_i[cand]) pick_idx = cand;
        end
    end
`endif

    always_comb begin
        state_next    = state_reg;
        owner_next    = owner_reg;
        lock_cnt_next = lock_cnt_reg;
        last_ptr_next = last_ptr_reg;
        lock_err_next = 1'b0;
        gnt           = '0;
        // The owner keeps the memory while it requests or still asserts lock.
        owner_holds = (state_reg == S_LOCKED) && (req_i[owner_reg] || lock_i[owner_reg]);
        if (owner_holds) begin
            gnt[owner_reg] = req_i[owner_reg];
            if (!lock_i[owner_reg]) begin
                state_next    = S_ARB;
                lock_cnt_next = '0;
            end else if (lock_cnt_reg >= CNT_LAST) begin
                state_next    = S_ARB;
                lock_cnt_next = '0;
                lock_err_next = 1'b1;
            end else begin
                lock_cnt_next = lock_cnt_reg + 1'b1;
            end
        end else begin
            state_next    = S_ARB;
            lock_cnt_next = '0;
            if (pick_found) begin
                gnt[pick_idx] = 1'b1;
                if (lock_i[pick_idx]) begin
                    state_next    = S_LOCKED;
                    owner_next    = pick_idx;
                    lock_cnt_next = CNT_W'(1);
                end
            end
        end
`ifndef ARB_FIXED_PRIO_EN
        if (|gnt) last_ptr_next = owner_holds ? owner_reg : pick_idx;
`endif
    end

    always_comb begin
        gnt_o     = rst_i ? '0 : gnt;
        mem_addr  = '0;
        mem_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_o[i]) begin
                mem_addr  = addr_arr[i];
                mem_wdata = wdata_arr[i];
            end
        end
    end

    assign mem_read   = |(gnt_o & ~we_i);
    assign mem_write  = |(gnt_o & we_i);
    assign rvalid_o   = rst_i ? '0 : rvalid_reg;
    assign rdata_o    = mem_rdata;
    assign lock_err_o = lock_err_reg & ~rst_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg    <= S_ARB;
            last_ptr_reg <= LAST_IDX;
            owner_reg    <= '0;
            lock_cnt_reg <= '0;
            rvalid_reg   <= '0;
            lock_err_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            last_ptr_reg <= last_ptr_next;
            owner_reg    <= owner_next;
            lock_cnt_reg <= lock_cnt_next;
            rvalid_reg   <= gnt & ~we_i;
            lock_err_reg <= lock_err_next;
        end
    end
endmodule
